// File: rtl/bcd_pkg.sv
// Shared BCD types and constants for the scanned BCD counter.
//   bcd_digit_t  : one packed BCD digit (4 bits)
//   BCD_MAX      : largest legal digit value
//   NUM_DIGITS   : digits held by the counter
//   scan_state_t : digit-scan FSM encoding (DIG0..DIG3)
//   bcd_clamp()  : saturates an illegal nibble (A..F) to BCD_MAX
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t  BCD_MAX    = 4'd9;
  localparam int unsigned NUM_DIGITS = 4;

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } scan_state_t;

  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit of a ripple up/down counter.
//   clk, rst   : clock, asynchronous active-high reset
//   load       : synchronous load of load_digit (clamped to 9), overrides stepping
//   load_digit : digit value to load
//   step_in    : this digit steps this cycle (enable from the stage below)
//   up         : 1 = increment, 0 = decrement
//   digit      : registered digit value
//   step_out   : this digit wraps on this step, so the next digit must step
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_digit,
  input  logic       step_in,
  input  logic       up,
  output logic [3:0] digit,
  output logic       step_out
);

  logic at_limit;

  // Wrap point is 9 when counting up, 0 when counting down.
  assign at_limit = up ? (digit == BCD_MAX) : (digit == 4'd0);
  assign step_out = step_in & at_limit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit <= '0;
    end else if (load) begin
      digit <= bcd_clamp(load_digit);
    end else if (step_in) begin
      if (up) digit <= at_limit ? 4'd0 : digit + 4'd1;
      else    digit <= at_limit ? BCD_MAX : digit - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_scan_counter.sv
// Four-digit BCD up/down counter with multiplexed seven-segment scan output.
//   clk, rst   : clock, asynchronous active-high reset
//   en, up     : count enable and direction (1 = up)
//   load       : synchronous load of load_val (digits >9 stored as 9), overrides en
//   load_val   : packed BCD load value, [3:0] = units
//   count      : registered packed BCD count
//   carry      : one-cycle pulse after a 9999<->0000 wrap step
//   w,x,y,z    : BCD nibble of the scanned digit (w = MSB)
//   dig_sel    : one-hot digit enable, aligned with {w,x,y,z}
module bcd_scan_counter
  import bcd_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 1000,
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        up,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] count,
  output logic        carry,
  output logic        w,
  output logic        x,
  output logic        y,
  output logic        z,
  output logic [3:0]  dig_sel
);

  // ---------------- counter chain ----------------
  logic [NUM_DIGITS:0] step;

  assign step[0] = en & ~load;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit_cell u_cell (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .load_digit (load_val[4*i +: 4]),
      .step_in    (step[i]),
      .up         (up),
      .digit      (count[4*i +: 4]),
      .step_out   (step[i+1])
    );
  end

  // A step out of the top digit is exactly a full 9999<->0000 wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) carry <= 1'b0;
    else     carry <= step[NUM_DIGITS];
  end

  // ---------------- prescaler and scan FSM ----------------
  logic [15:0] presc;
  logic        presc_wrap;
  scan_state_t state, state_nxt;
  logic [3:0]  digit_nxt;

  assign presc_wrap = (presc == 16'(SCAN_DIV - 1));

  always_comb begin
    state_nxt = state;
    if (presc_wrap) begin
      unique case (state)
        DIG0:    state_nxt = DIG1;
        DIG1:    state_nxt = DIG2;
        DIG2:    state_nxt = DIG3;
        DIG3:    state_nxt = DIG0;
        default: state_nxt = DIG0;
      endcase
    end
  end

  // Nibble and select are both loaded from state_nxt so they switch on the
  // same edge; the nibble therefore trails count by exactly one cycle.
  always_comb begin
    digit_nxt = count[3:0];
    case (state_nxt)
      DIG0:    digit_nxt = count[3:0];
      DIG1:    digit_nxt = count[7:4];
      DIG2:    digit_nxt = count[11:8];
      DIG3:    digit_nxt = count[15:12];
      default: digit_nxt = count[3:0];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc     <= '0;
      state     <= DIG0;
      dig_sel   <= 4'b0001;
      {w,x,y,z} <= '0;
    end else begin
      presc     <= presc_wrap ? '0 : presc + 16'd1;
      state     <= state_nxt;
      dig_sel   <= 4'b0001 << state_nxt;
      {w,x,y,z} <= digit_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_scan_counter.sv
module tb_bcd_scan_counter;

  localparam int unsigned SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        rst, en, up, load;
  logic [15:0] load_val;
  logic [15:0] count;
  logic        carry, w, x, y, z;
  logic [3:0]  dig_sel;

  always #5 clk = ~clk;

  bcd_scan_counter #(.SCAN_DIV(SCAN_DIV), .NUM_DIGITS(4)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(count), .carry(carry), .w(w), .x(x), .y(y), .z(z), .dig_sel(dig_sel)
  );

  typedef struct packed {
    logic [15:0] cnt;
    logic        cy;
    logic [3:0]  nib;
    logic [3:0]  sel;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  // reference model state (decimal count, prescaler, scan index)
  int m_count, m_presc, m_state;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    t = v;
    r = 16'h0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int clamp_val(input logic [15:0] lv);
    int r, mul, nib;
    r = 0;
    mul = 1;
    for (int i = 0; i < 4; i++) begin
      nib = int'(lv[4*i +: 4]);
      if (nib > 9) nib = 9;
      r += nib * mul;
      mul *= 10;
    end
    return r;
  endfunction

  function automatic int digit_of(input int v, input int idx);
    int t;
    t = v;
    for (int i = 0; i < idx; i++) t = t / 10;
    return t % 10;
  endfunction

  task automatic model_reset();
    m_count = 0;
    m_presc = 0;
    m_state = 0;
    sb.delete();
  endtask

  task automatic check_reset(input string tag);
    check_val({tag, "_count"}, count, 16'h0000);
    check_val({tag, "_carry"}, 16'(carry), 16'h0);
    check_val({tag, "_wxyz"}, 16'({w,x,y,z}), 16'h0);
    check_val({tag, "_sel"}, 16'(dig_sel), 16'h1);
  endtask

  // Drive one cycle of stimulus (called just after a sample point),
  // push the model's prediction, then compare after the edge.
  task automatic cycle(input string tag, input logic e, input logic u,
                       input logic l, input logic [15:0] lv);
    exp_t xp, got;
    int old;
    en = e; up = u; load = l; load_val = lv;
    old = m_count;
    xp.cy = 1'b0;
    if (l) begin
      m_count = clamp_val(lv);
    end else if (e) begin
      if (u) begin
        if (old == 9999) begin m_count = 0; xp.cy = 1'b1; end
        else m_count = old + 1;
      end else begin
        if (old == 0) begin m_count = 9999; xp.cy = 1'b1; end
        else m_count = old - 1;
      end
    end
    if (m_presc == SCAN_DIV - 1) begin
      m_presc = 0;
      m_state = (m_state + 1) % 4;
    end else begin
      m_presc++;
    end
    xp.cnt = to_bcd(m_count);
    xp.nib = 4'(digit_of(old, m_state));
    xp.sel = 4'(1 << m_state);
    sb.push_back(xp);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_sb: scoreboard empty", tag);
    end else begin
      got = sb.pop_front();
      check_val({tag, "_count"}, count, got.cnt);
      check_val({tag, "_carry"}, 16'(carry), 16'(got.cy));
      check_val({tag, "_wxyz"}, 16'({w,x,y,z}), 16'(got.nib));
      check_val({tag, "_sel"}, 16'(dig_sel), 16'(got.sel));
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 16'h0;
    model_reset();
    #2;
    check_reset("rst_init");
    @(negedge clk);
    rst = 1'b0;

    // 0999 + 1 -> 1000, no carry
    cycle("ld0999", 1'b0, 1'b1, 1'b1, 16'h0999);
    cycle("inc1000", 1'b1, 1'b1, 1'b0, 16'h0);

    // full wrap up then down, each with a one-cycle carry
    cycle("ld9999", 1'b0, 1'b1, 1'b1, 16'h9999);
    cycle("wrap_up", 1'b1, 1'b1, 1'b0, 16'h0);
    cycle("hold0", 1'b0, 1'b1, 1'b0, 16'h0);
    cycle("wrap_dn", 1'b1, 1'b0, 1'b0, 16'h0);
    cycle("hold9", 1'b0, 1'b0, 1'b0, 16'h0);

    // load overrides en, illegal digits clamp to 9
    cycle("ld_clamp", 1'b1, 1'b1, 1'b1, 16'hFA3C);

    // multi-digit borrow
    cycle("ld1000", 1'b0, 1'b0, 1'b1, 16'h1000);
    cycle("dec0999", 1'b1, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 3; i++) cycle("hold", 1'b0, 1'b1, 1'b0, 16'h0);

    // scan 4321 across all digits
    cycle("ld4321", 1'b0, 1'b1, 1'b1, 16'h4321);
    for (int i = 0; i < 32; i++) cycle("scan", 1'b0, 1'b1, 1'b0, 16'h0);

    // counting across a wrap while scanning
    cycle("ld9995", 1'b0, 1'b1, 1'b1, 16'h9995);
    for (int i = 0; i < 10; i++) cycle("run_up", 1'b1, 1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 10; i++) cycle("run_dn", 1'b1, 1'b0, 1'b0, 16'h0);

    // random operations
    for (int i = 0; i < 150; i++) begin
      cycle("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0), 16'($urandom));
    end

    // asynchronous reset mid-scan
    cycle("ld0057", 1'b0, 1'b1, 1'b1, 16'h0057);
    for (int i = 0; i < 6; i++) cycle("pre_rst", 1'b0, 1'b1, 1'b0, 16'h0);
    #2;
    rst = 1'b1;
    #1;
    check_reset("rst_async");
    model_reset();
    @(posedge clk);
    #1;
    check_reset("rst_held");
    @(negedge clk);
    rst = 1'b0;

    // first edge after reset honours load; scan restarts at digit 0
    cycle("post_ld", 1'b0, 1'b1, 1'b1, 16'h8642);
    for (int i = 0; i < 12; i++) cycle("post_scan", 1'b1, 1'b0, 1'b0, 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/bcd_scan_counter.md
BCD_SCAN_COUNTER -- requirements
Module: bcd_scan_counter

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000, clk cycles per displayed digit (legal range 2..65535).
REQ-002 SHALL have parameter NUM_DIGITS, default 4, BCD digits held; fixed at 4 in this revision.
REQ-003 SHALL have one clock and an asynchronous, active-high reset, with ports named as follows.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 en  in  1  count enable; one step per cycle while high.
REQ-007 up  in  1  direction: 1 = increment, 0 = decrement; sampled with en.
REQ-008 load  in  1  synchronous load of load_val; overrides en.
REQ-009 load_val  in  16  four BCD digits, [3:0] = digit0 (units).
REQ-010 count  out  16  current counter value, packed BCD, registered.
REQ-011 carry  out  1  one-cycle pulse on wrap (9999->0000 up, 0000->9999 down).
REQ-012 w,x,y,z  out  1 each  BCD nibble of the scanned digit for the seven-segment decoder; w = bit3 (MSB), z = bit0.
REQ-013 dig_sel  out  4  one-hot digit enable, bit n = digit n; active-high.

Function
REQ-014 Counter SHALL hold 0000..9999 in packed BCD; no digit SHALL ever exceed 9.
REQ-015 load=1: count SHALL equal load_val next cycle; any load_val digit >9 SHALL be stored as 9; carry SHALL be 0 that cycle.
REQ-016 load=0, en=1, up=1: count SHALL increment by 1 decimal, with a digit at 9 wrapping to 0 and carrying into the next digit.
REQ-017 load=0, en=1, up=0: count SHALL decrement by 1 decimal, with a digit at 0 wrapping to 9 and borrowing from the next digit.
REQ-018 carry SHALL be 1 for exactly the cycle after an en step that wraps 9999->0000 (up) or 0000->9999 (down), and 0 otherwise.
REQ-019 en=0 and load=0: count SHALL hold.
REQ-020 Counter update latency: 1 cycle from input edge to count.
REQ-021 Scan prescaler SHALL count 0..SCAN_DIV-1 and wrap; the scan FSM SHALL advance one state on each prescaler wrap.
REQ-022 Scan FSM states: DIG0->DIG1->DIG2->DIG3->DIG0; no other transitions; unreachable encodings SHALL return to DIG0.
REQ-023 dig_sel SHALL be the one-hot encoding of the FSM state, and exactly one bit SHALL be high at all times outside reset.
REQ-024 {w,x,y,z} SHALL be registered and equal to count's digit selected by the current state, aligned to the same cycle as dig_sel (no skew).
REQ-025 A count change while a digit is being displayed SHALL appear on {w,x,y,z} one cycle after count updates.
REQ-026 Load and count operations SHALL NOT disturb the prescaler or the scan state.

Reset
REQ-027 While rst=1, outputs SHALL be: count=0000, carry=0, {w,x,y,z}=0000, dig_sel=0001, scan state DIG0, prescaler=0.
REQ-028 Reset asserted mid-count or mid-scan SHALL take effect immediately, without waiting for a clock.
REQ-029 On the first clk edge after rst deasserts, en and load SHALL be honoured.

Structure
REQ-030 A shared package bcd_pkg SHALL hold the BCD digit type (4 bits), BCD_MAX=9, NUM_DIGITS=4 and the scan-state encoding.
REQ-031 A sub-module bcd_digit_cell SHALL implement one digit (inc/dec, carry/borrow in and out, load, clamp) and SHALL be instantiated NUM_DIGITS times in a ripple chain.
REQ-032 The prescaler and scan FSM SHALL live in bcd_scan_counter.

Verification
REQ-033 Reset, then load 0x0999, en=1 up=1 for 1 cycle -> count=0x1000, carry=0.
REQ-034 Load 0x9999, en=1 up=1 -> count=0x0000 with a carry pulse of 1 cycle; then en=1 up=0 -> count=0x9999 with a carry pulse of 1 cycle.
REQ-035 load=1 with load_val=0xFA3C and en=1 in the same cycle -> count=0x9939 and carry=0.
REQ-036 SCAN_DIV=4, count=0x4321, run 32 cycles -> dig_sel steps 0001,0010,0100,1000 every 4 cycles while {w,x,y,z} = 1,2,3,4 respectively, and dig_sel stays one-hot.
REQ-037 Assert rst asynchronously mid-scan with count=0x0057 -> all outputs at reset values before the next clk edge.
